// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a single-port SRAM: one transaction in flight,
// fixed latency of 3 + WAIT_CYCLES cycles from acceptance to data_ok.
module dbus_sram_responder #(
    parameter int unsigned AW          = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          is_write,
    input  logic [31:0]   addr,
    input  logic [31:0]   data,
    input  logic [3:0]    write_en,
    input  logic [1:0]    size,
    input  logic          cache_op_req,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [31:0]   rdata,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             is_write_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [3:0]       write_en_q;
    logic [1:0]       size_q;
    logic             cache_op_q;
    logic [31:0]      rdata_q;
    logic             sram_en_q;
    logic [3:0]       sram_we_q;
    logic             data_ok_q;

    // Strobes are qualified by reset so a pending store is dropped in the reset cycle itself.
    assign addr_ok    = reset & req & (state_q == IDLE);
    assign data_ok    = reset & data_ok_q;
    assign sram_en    = reset & sram_en_q;
    assign sram_we    = sram_we_q & {4{reset}};
    assign sram_addr  = addr_q[AW+1:2];
    assign sram_wdata = data_q;
    assign rdata      = rdata_q;

    // size and the byte offset are carried through but never interpreted.
    logic unused_fields;
    assign unused_fields = ^{size_q, addr_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            write_en_q <= '0;
            size_q     <= '0;
            cache_op_q <= 1'b0;
            rdata_q    <= '0;
            sram_en_q  <= 1'b0;
            sram_we_q  <= '0;
            data_ok_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        is_write_q <= is_write;
                        addr_q     <= addr;
                        data_q     <= data;
                        write_en_q <= write_en;
                        size_q     <= size;
                        cache_op_q <= cache_op_req;
                        sram_en_q  <= ~cache_op_req;
                        sram_we_q  <= (is_write && !cache_op_req) ? write_en : 4'b0000;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_en_q  <= 1'b0;
                    sram_we_q  <= 4'b0000;
                    wait_cnt_q <= WAIT_INIT;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // Counter still at its start value only on the first WAIT cycle.
                    if (wait_cnt_q == WAIT_INIT) begin
                        rdata_q <= (is_write_q || cache_op_q) ? 32'h0 : sram_rdata;
                    end
                    if (wait_cnt_q == '0) begin
                        data_ok_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    data_ok_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: one responder with no wait states, one with three, each on its own SRAM model.
`timescale 1ns/1ps
module tb_dbus_sram_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req0, req1, is_write, cache_op_req;
    logic [31:0] addr, data;
    logic [3:0]  write_en;
    logic [1:0]  size;

    logic        addr_ok0, data_ok0, sram_en0, addr_ok1, data_ok1, sram_en1;
    logic [31:0] rdata0, sram_wdata0, sram_rdata0, rdata1, sram_wdata1, sram_rdata1;
    logic [3:0]  sram_we0, sram_we1;
    logic [15:0] sram_addr0, sram_addr1;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    int checks = 0;
    int errors = 0;

    dbus_sram_responder #(.AW(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .is_write(is_write), .addr(addr),
        .data(data), .write_en(write_en), .size(size), .cache_op_req(cache_op_req),
        .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .sram_en(sram_en0),
        .sram_we(sram_we0), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
        .sram_rdata(sram_rdata0)
    );

    dbus_sram_responder #(.AW(16), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .is_write(is_write), .addr(addr),
        .data(data), .write_en(write_en), .size(size), .cache_op_req(cache_op_req),
        .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1), .sram_en(sram_en1),
        .sram_we(sram_we1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
        .sram_rdata(sram_rdata1)
    );

    // Synchronous SRAM models: read-first, data one cycle after the strobe.
    always @(posedge clk) begin
        if (sram_en0) begin
            for (int b = 0; b < 4; b++)
                if (sram_we0[b]) mem0[sram_addr0[5:0]][8*b +: 8] <= sram_wdata0[8*b +: 8];
            sram_rdata0 <= mem0[sram_addr0[5:0]];
        end
        if (sram_en1) begin
            for (int b = 0; b < 4; b++)
                if (sram_we1[b]) mem1[sram_addr1[5:0]][8*b +: 8] <= sram_wdata1[8*b +: 8];
            sram_rdata1 <= mem1[sram_addr1[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the zero-wait instance, starting in an IDLE cycle.
    task automatic xact0(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic cop,
                         input logic [1:0] sz, input logic [31:0] exp_rdata);
        req0 = 1'b1; is_write = wr; addr = a; data = d; write_en = be;
        cache_op_req = cop; size = sz;
        #1 check({tag, "_addr_ok"}, 32'(addr_ok0), 32'd1);
        tick();
        req0 = 1'b0; is_write = ~wr; addr = 32'hFFFF_FFFC; data = ~d;
        write_en = ~be; cache_op_req = ~cop; size = ~sz;
        #1;
        check({tag, "_acc_en"}, 32'(sram_en0), cop ? 32'd0 : 32'd1);
        check({tag, "_acc_we"}, 32'(sram_we0), (wr && !cop) ? 32'(be) : 32'd0);
        if (!cop) begin
            check({tag, "_acc_addr"}, 32'(sram_addr0), {16'h0, a[17:2]});
            check({tag, "_acc_wdata"}, sram_wdata0, d);
        end
        check({tag, "_acc_dok"}, 32'(data_ok0), 32'd0);
        tick();
        #1;
        check({tag, "_wait_en"}, 32'(sram_en0), 32'd0);
        check({tag, "_wait_dok"}, 32'(data_ok0), 32'd0);
        tick();
        #1;
        check({tag, "_dok"}, 32'(data_ok0), 32'd1);
        check({tag, "_rdata"}, rdata0, exp_rdata);
        check({tag, "_resp_en"}, 32'(sram_en0), 32'd0);
        tick();
        #1;
        check({tag, "_dok_end"}, 32'(data_ok0), 32'd0);
        check({tag, "_rdata_hold"}, rdata0, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem0[2] = 32'hAABB_CCDD;
        mem0[4] = 32'hDEAD_BEEF;
        mem0[5] = 32'h5555_0005;
        mem0[6] = 32'h6666_0006;
        mem0[8] = 32'h0101_0101;
        mem1[3] = 32'h0BAD_F00D;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; is_write = 1'b0; cache_op_req = 1'b0;
        addr = 32'h0; data = 32'h0; write_en = 4'h0; size = 2'd0;
        tick();
        req0 = 1'b1; req1 = 1'b1; is_write = 1'b1; write_en = 4'hF; addr = 32'h10;
        tick();
        #1;
        check("rst_addr_ok0", 32'(addr_ok0), 32'd0);
        check("rst_addr_ok1", 32'(addr_ok1), 32'd0);
        check("rst_data_ok", 32'(data_ok0), 32'd0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_sram_en", 32'(sram_en0), 32'd0);
        check("rst_sram_we", 32'(sram_we0), 32'd0);
        check("rst_sram_addr", 32'(sram_addr0), 32'd0);
        check("rst_sram_wdata", sram_wdata0, 32'h0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;

        xact0("ld", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 2'd2, 32'hDEAD_BEEF);
        xact0("st", 1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0011, 1'b0, 2'd1, 32'h0);
        check("st_mem", mem0[2], 32'hAABB_3344);
        xact0("ld_misal", 1'b0, 32'h0000_000A, 32'h0, 4'h0, 1'b0, 2'd0, 32'hAABB_3344);
        xact0("cop", 1'b1, 32'h0000_0010, 32'h0, 4'hF, 1'b1, 2'd2, 32'h0);
        check("cop_mem", mem0[4], 32'hDEAD_BEEF);

        // Back-to-back loads with req held high.
        req0 = 1'b1; is_write = 1'b0; cache_op_req = 1'b0; write_en = 4'h0; addr = 32'h14;
        #1 check("b2b_ok1", 32'(addr_ok0), 32'd1);
        tick();
        addr = 32'h18;
        #1;
        check("b2b_acc1_ok", 32'(addr_ok0), 32'd0);
        check("b2b_acc1_addr", 32'(sram_addr0), 32'd5);
        tick();
        #1 check("b2b_wait1_ok", 32'(addr_ok0), 32'd0);
        tick();
        #1;
        check("b2b_dok1", 32'(data_ok0), 32'd1);
        check("b2b_rdata1", rdata0, 32'h5555_0005);
        check("b2b_resp1_ok", 32'(addr_ok0), 32'd0);
        tick();
        #1;
        check("b2b_ok2", 32'(addr_ok0), 32'd1);
        check("b2b_idle_dok", 32'(data_ok0), 32'd0);
        tick();
        req0 = 1'b0;
        #1;
        check("b2b_acc2_en", 32'(sram_en0), 32'd1);
        check("b2b_acc2_addr", 32'(sram_addr0), 32'd6);
        tick();
        tick();
        #1;
        check("b2b_dok2", 32'(data_ok0), 32'd1);
        check("b2b_rdata2", rdata0, 32'h6666_0006);
        tick();

        // Three wait states, req held high throughout.
        req1 = 1'b1; is_write = 1'b0; addr = 32'h0C;
        #1 check("ws_ok", 32'(addr_ok1), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            check($sformatf("ws_mid%0d_ok", k), 32'(addr_ok1), 32'd0);
            check($sformatf("ws_mid%0d_dok", k), 32'(data_ok1), 32'd0);
        end
        tick();
        #1;
        check("ws_dok", 32'(data_ok1), 32'd1);
        check("ws_rdata", rdata1, 32'h0BAD_F00D);
        check("ws_resp_ok", 32'(addr_ok1), 32'd0);
        tick();
        #1 check("ws_ok2", 32'(addr_ok1), 32'd1);
        tick();
        req1 = 1'b0;
        #1 check("ws2_acc_en", 32'(sram_en1), 32'd1);
        for (int k = 9; k <= 12; k++) begin
            tick();
            #1 check($sformatf("ws2_t%0d_dok", k), 32'(data_ok1), 32'd0);
        end
        tick();
        #1;
        check("ws2_dok", 32'(data_ok1), 32'd1);
        check("ws2_rdata", rdata1, 32'h0BAD_F00D);
        tick();

        // Reset in the ACCESS cycle of a store.
        req0 = 1'b1; is_write = 1'b1; addr = 32'h20; data = 32'hCAFE_F00D; write_en = 4'hF;
        #1 check("rm_ok", 32'(addr_ok0), 32'd1);
        tick();
        req0 = 1'b0; reset = 1'b0;
        #1;
        check("rm_we", 32'(sram_we0), 32'd0);
        check("rm_en", 32'(sram_en0), 32'd0);
        tick();
        #1;
        check("rm_post_dok", 32'(data_ok0), 32'd0);
        check("rm_post_ok", 32'(addr_ok0), 32'd0);
        check("rm_post_rdata", rdata0, 32'h0);
        check("rm_post_en", 32'(sram_en0), 32'd0);
        check("rm_post_we", 32'(sram_we0), 32'd0);
        check("rm_post_addr", 32'(sram_addr0), 32'd0);
        check("rm_post_wdata", sram_wdata0, 32'h0);
        tick();
        #1 check("rm_hold_dok", 32'(data_ok0), 32'd0);
        check("rm_mem", mem0[8], 32'h0101_0101);
        reset = 1'b1;
        xact0("rm_ld", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 2'd2, 32'h0101_0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
